seq_shifter: RTL and testbench

Parametrised multi-cycle shifter for the datapath. It supports logical left, logical right, arithmetic right and rotate right by a variable amount, and is the general successor to the fixed shift-left-by-2 unit. The datapath issues one operation through a valid/ready input handshake and collects the result through a valid/ready output handshake. Each cycle shifts by at most STEP bits, which trades latency against area.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_stage.sv | 38 +++
 rtl/seq_shifter.sv | 103 ++++++++++
 tb/tb_seq_shifter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the sequential shifter: operation encoding and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_stage.sv
// Combinational single-step shifter: shifts data by k in 0..STEP for the selected op.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  parameter int unsigned KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_op_e        op_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] data_o
);

  function automatic logic [WIDTH-1:0] shift_const(logic [WIDTH-1:0] d, shift_op_e op,
                                                   int unsigned s);
    logic [WIDTH-1:0] res;
    unique case (op)
      SHIFT_SLL: res = d << s;
      SHIFT_SRL: res = d >> s;
      SHIFT_SRA: res = WIDTH'($signed(d) >>> s);
      SHIFT_ROR: res = (s == 0) ? d : ((d >> s) | (d << (WIDTH - s)));
      default:   res = d;
    endcase
    return res;
  endfunction

  // One constant-amount shifter per legal k, selected by k_i.
  always_comb begin
    data_o = data_i;
    for (int unsigned s = 0; s <= STEP; s++) begin
      if (k_i == KW'(s)) begin
        data_o = shift_const(data_i, op_i, s);
      end
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: accepts one op via valid/ready, shifts up to STEP bits per cycle,
// then holds the result until the consumer takes it.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP    = 4,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int unsigned KW = $clog2(STEP + 1);

  shift_state_e       state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  shift_op_e          op_q, op_d;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   stage_out;

  always_comb begin
    if (32'(rem_q) < STEP) begin
      k = KW'(rem_q);
    end else begin
      k = KW'(STEP);
    end
  end

  shift_stage #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_stage (
    .data_i (data_q),
    .op_i   (op_q),
    .k_i    (k),
    .data_o (stage_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    op_d    = op_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          rem_d   = in_shamt;
          op_d    = shift_op_e'(in_op);
          state_d = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d = stage_out;
        rem_d  = rem_q - SHAMT_W'(k);
        if (rem_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode only from registered state, so no input reaches an output combinationally.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    out_data  = (state_q == ST_DONE) ? data_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= SHIFT_SLL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Randomised self-checking bench for seq_shifter (WIDTH 32, STEP 4) against a behavioural model.
module tb_seq_shifter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned STEP  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [4:0]        in_shamt;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              busy;

  int n_checks = 0;
  int n_fails  = 0;

  seq_shifter #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_shamt  (in_shamt),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input int sh,
                                            input logic [31:0] d);
    logic [63:0] ext;
    ext = {{32{d[31]}}, d};
    case (op)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b10:   return 32'(ext >> sh);
      default: return (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
    endcase
  endfunction

  function automatic int ref_latency(input int sh);
    return (sh + STEP - 1) / STEP + 1;
  endfunction

  // Called #1 after a rising edge with the DUT idle.
  task automatic do_op(input logic [1:0] op, input int sh, input logic [31:0] d,
                       input logic [31:0] exp, input int hold, input bit pulse_valid);
    int lat;
    in_valid = 1'b1;
    in_op    = op;
    in_shamt = 5'(sh);
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs after the accept edge; they must not matter.
    in_op    = 2'($urandom);
    in_shamt = 5'($urandom);
    in_data  = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready !== 1'b0) check("in_ready_low_shift", in_ready, 0);
      in_valid = pulse_valid ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, ref_latency(sh));
    check("result", out_data, exp);
    check("busy_done", busy, 1);
    for (int i = 0; i < hold; i++) begin
      in_valid = pulse_valid ? ~in_valid : 1'b0;
      @(posedge clk); #1;
      check("hold_data", out_data, exp);
      check("hold_ready", in_ready, 0);
      check("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ready_return", in_ready, 1);
    check("valid_drop", out_valid, 0);
    check("data_zero", out_data, 0);
  endtask

  initial begin
    logic [1:0]  op;
    int          sh;
    logic [31:0] d;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_shamt  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(2'b00, 2,  32'h0000_0001, 32'h0000_0004, 0, 0);
    do_op(2'b10, 31, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op(2'b01, 31, 32'h8000_0000, 32'h0000_0001, 0, 0);
    do_op(2'b11, 4,  32'h0000_00F1, 32'h1000_000F, 0, 0);
    do_op(2'b11, 1,  32'h8000_0001, 32'hC000_0000, 0, 0);
    do_op(2'b01, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
    // Backpressure with in_valid pulses that must be ignored.
    do_op(2'b10, 7,  32'hF000_1234, 32'hFFE0_0024, 5, 1);
    do_op(2'b00, 5,  32'h0000_0013, 32'h0000_0260, 0, 0);

    // Reset between edges while shifting an SRL by 20.
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_shamt = 5'd20;
    in_data  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_data", out_data, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("no_stale_valid", out_valid, 0);
    end
    do_op(2'b00, 8, 32'h0000_0003, 32'h0000_0300, 0, 0);

    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom);
      sh = int'($urandom_range(0, 31));
      d  = $urandom;
      do_op(op, sh, d, ref_shift(op, sh, d), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
